// File: rtl/iob_fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a synchronous FIFO write port.
// N_REQ requesters compete for the port; the winner holds it for up to
// MAX_BURST words, or until it drops valid, then the port is re-arbitrated
// starting just after the previous winner. Every new grant costs one IDLE
// cycle in which nothing is written.
module iob_fifo_wr_arbiter #(
    parameter int W_DATA_W  = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int BC_W     = $clog2(MAX_BURST) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*W_DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_write_en,
    output logic [W_DATA_W-1:0]       fifo_data_in,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Lookup tables are padded to a power of two so any grant_id value
    // indexes a real entry; the padding entries never win arbitration.
    localparam int N_PAD = 1 << ID_W;

    logic [0:0]          state_reg, state_next;
    logic [ID_W-1:0]     grant_id_reg, grant_id_next;
    logic [ID_W-1:0]     last_id_reg, last_id_next;
    logic [BC_W-1:0]     burst_cnt_reg, burst_cnt_next;

    logic [W_DATA_W-1:0] word_pad  [N_PAD];
    logic                valid_pad [N_PAD];

    logic [ID_W-1:0]     pick_id;
    logic                pick_found;
    logic                valid_sel;
    logic                xfer;
    logic                last_word;

    genvar gi;

    generate
        for (gi = 0; gi < N_PAD; gi++) begin : g_pad
            if (gi < N_REQ) begin : g_real
                assign word_pad[gi]  = req_data[gi*W_DATA_W +: W_DATA_W];
                assign valid_pad[gi] = req_valid[gi];
            end else begin : g_fill
                assign word_pad[gi]  = '0;
                assign valid_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign valid_sel     = valid_pad[grant_id_reg];
    assign xfer          = (state_reg == ST_GRANT) && valid_sel && !fifo_full;
    assign last_word     = (burst_cnt_reg == BC_W'(MAX_BURST - 1));

    assign fifo_write_en = xfer;
    assign fifo_data_in  = word_pad[grant_id_reg];
    assign grant_id      = grant_id_reg;
    assign busy          = (state_reg == ST_GRANT);

    // Only the granted requester can ever see ready, and only on a real transfer.
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = xfer && (grant_id_reg == ID_W'(gi));
        end
    endgenerate

    // Round-robin search: first valid requester after last_id, wrapping.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_id_reg) + k) % N_REQ;
            if (!pick_found && valid_pad[ID_W'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count and release in GRANT.
    always_comb begin
        state_next     = state_reg;
        grant_id_next  = grant_id_reg;
        last_id_next   = last_id_reg;
        burst_cnt_next = burst_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_next  = pick_id;
                    burst_cnt_next = '0;
                    state_next     = ST_GRANT;
                end
            end
            default: begin
                if (!valid_sel) begin
                    // Requester withdrew: give up the port, leftovers re-arbitrate.
                    state_next   = ST_IDLE;
                    last_id_next = grant_id_reg;
                end else if (xfer) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                    if (last_word) begin
                        state_next   = ST_IDLE;
                        last_id_next = grant_id_reg;
                    end
                end
                // valid with fifo_full: hold everything until space appears
            end
        endcase
    end

    // State registers; reset gives requester 0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            grant_id_reg  <= '0;
            last_id_reg   <= ID_W'(N_REQ - 1);
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_id_reg  <= grant_id_next;
            last_id_reg   <= last_id_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

endmodule

// File: tb/tb_iob_fifo_wr_arbiter.sv
// Directed bench for iob_fifo_wr_arbiter (4 requesters, bursts of 4, 8-bit words).
// Requesters are modelled as word queues; every FIFO write is matched against
// a hand-built list of {requester, word} in the order they must appear.
module tb_iob_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_write_en;
    logic [7:0]  fifo_data_in;
    logic [1:0]  grant_id;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] q0[$], q1[$], q2[$], q3[$];
    logic [9:0] exp_q[$];

    iob_fifo_wr_arbiter #(
        .W_DATA_W  (8),
        .N_REQ     (4),
        .MAX_BURST (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_full     (fifo_full),
        .fifo_write_en (fifo_write_en),
        .fifo_data_in  (fifo_data_in),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_src(input int r, input logic [7:0] d);
        case (r)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic pop_src(input int r);
        case (r)
            0: if (q0.size() > 0) void'(q0.pop_front());
            1: if (q1.size() > 0) void'(q1.pop_front());
            2: if (q2.size() > 0) void'(q2.pop_front());
            default: if (q3.size() > 0) void'(q3.pop_front());
        endcase
    endtask

    function automatic int src_size(input int r);
        case (r)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [7:0] src_front(input int r);
        if (src_size(r) == 0) return 8'h00;
        case (r)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    task automatic clear_src();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endtask

    task automatic update_inputs();
        for (int r = 0; r < 4; r++) begin
            req_valid[r]       = (src_size(r) != 0);
            req_data[r*8 +: 8] = src_front(r);
        end
    endtask

    task automatic expect_wr(input int r, input logic [7:0] d);
        exp_q.push_back({2'(r), d});
    endtask

    // One clock: check the write port at the falling edge, then apply
    // accepted handshakes and new inputs just after the rising edge.
    task automatic step();
        logic [3:0] hs;
        logic [9:0] e;
        @(negedge clk);
        chk("wr_vs_full", 32'(fifo_write_en & fifo_full), 32'd0);
        if (fifo_write_en) begin
            $display("wr t=%0t id=%0d data=%02h", $time, grant_id, fifo_data_in);
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", 32'(fifo_data_in), 32'(e[7:0]));
                chk("wr_ready", 32'(req_ready), 32'd1 << e[9:8]);
            end
        end else begin
            chk("no_wr_ready", 32'(req_ready), 32'd0);
        end
        hs = rst ? 4'b0000 : req_ready;
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) if (hs[r]) pop_src(r);
        update_inputs();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fifo_full = 1'b0;
        clear_src();
        exp_q.delete();
        update_inputs();
        step();
        step();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_wr",    32'(fifo_write_en), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_gid",   32'(grant_id), 32'd0);
        rst = 1'b0;
        update_inputs();
    endtask

    // Per-cycle table: busy expected, granted id (when busy), fifo_full drive.
    task automatic run_vec(input string name, input int n, input logic [31:0] busy_pat,
                           input logic [63:0] gid_pat, input logic [31:0] full_pat);
        for (int k = 0; k < n; k++) begin
            fifo_full = full_pat[k];
            #1;
            chk($sformatf("%s_busy%0d", name, k), 32'(busy), 32'(busy_pat[k]));
            if (busy_pat[k])
                chk($sformatf("%s_gid%0d", name, k), 32'(grant_id), 32'(gid_pat[2*k +: 2]));
            step();
        end
        fifo_full = 1'b0;
    endtask

    initial begin
        logic [31:0] bp;
        logic [63:0] gp;

        // All four requesters always valid: order 0,1,2,3,0, 4 words each, one bubble between.
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 8; j++) push_src(r, 8'(r*16 + j));
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++) expect_wr(r, 8'(r*16 + j));
        for (int j = 4; j < 8; j++) expect_wr(0, 8'(j));
        update_inputs();
        bp = '0;
        gp = '0;
        for (int k = 0; k < 25; k++) begin
            bp[k]        = ((k % 5) != 0);
            gp[2*k +: 2] = 2'((k / 5) % 4);
        end
        run_vec("rr", 25, bp, gp, 32'h0);
        clear_src();
        update_inputs();
        step();
        chk("rr_all_written", 32'(exp_q.size()), 32'd0);

        // Only requester 2, six words: burst of 4, bubble, burst of 2, release on drop.
        do_reset();
        for (int j = 0; j < 6; j++) begin
            push_src(2, 8'(8'h10 + j));
            expect_wr(2, 8'(8'h10 + j));
        end
        update_inputs();
        run_vec("solo2", 10, 32'h1DE, {32{2'd2}}, 32'h0);
        chk("solo2_all_written", 32'(exp_q.size()), 32'd0);

        // Requester 1 stalled by fifo_full for 5 cycles after its second word.
        do_reset();
        for (int j = 0; j < 4; j++) begin
            push_src(1, 8'(8'h31 + j));
            expect_wr(1, 8'(8'h31 + j));
        end
        update_inputs();
        run_vec("stall1", 11, 32'h3FE, {32{2'd1}}, 32'hF8);
        chk("stall1_all_written", 32'(exp_q.size()), 32'd0);

        // Requester 3 sends 2 words then drops; then 0 and 2 compete, 0 first.
        do_reset();
        push_src(3, 8'h41); push_src(3, 8'h42);
        expect_wr(3, 8'h41); expect_wr(3, 8'h42);
        update_inputs();
        run_vec("drop3", 4, 32'hE, {32{2'd3}}, 32'h0);
        push_src(0, 8'h01); push_src(0, 8'h02); push_src(2, 8'h21);
        expect_wr(0, 8'h01); expect_wr(0, 8'h02); expect_wr(2, 8'h21);
        update_inputs();
        run_vec("after3", 8, 32'h6E, 64'h2800, 32'h0);
        chk("drop3_all_written", 32'(exp_q.size()), 32'd0);

        // Reset hits requester 2 with burst_cnt at 2; afterwards 0 wins over 2.
        do_reset();
        for (int j = 0; j < 6; j++) push_src(2, 8'(8'h51 + j));
        expect_wr(2, 8'h51); expect_wr(2, 8'h52);
        update_inputs();
        run_vec("pre_rst", 3, 32'h6, {32{2'd2}}, 32'h0);
        rst = 1'b1;
        push_src(0, 8'h01); push_src(0, 8'h02);
        update_inputs();
        #1;
        chk("midrst_busy",  32'(busy), 32'd0);
        chk("midrst_wr",    32'(fifo_write_en), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_gid",   32'(grant_id), 32'd0);
        step();
        rst = 1'b0;
        update_inputs();
        expect_wr(0, 8'h01); expect_wr(0, 8'h02);
        for (int j = 2; j < 6; j++) expect_wr(2, 8'(8'h51 + j));
        run_vec("post_rst", 10, 32'h1EE, 64'h2A800, 32'h0);
        chk("post_rst_all_written", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iob_fifo_wr_arbiter.md
IOB_FIFO_WR_ARBITER -- requirements
Module: iob_fifo_wr_arbiter

Interface
REQ-001 Parameter W_DATA_W, default 8, word width of each requester and of the FIFO write port.
REQ-002 Parameter N_REQ, default 4, number of requesters (2..16).
REQ-003 Parameter MAX_BURST, default 4, maximum words transferred per grant (1..256).
REQ-004 Derived ID_W = max(1, clog2(N_REQ)); derived BC_W = clog2(MAX_BURST)+1.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_valid  input  N_REQ  bit i: requester i presents a word.
REQ-008 req_data  input  N_REQ*W_DATA_W  requester i word at bits [i*W_DATA_W +: W_DATA_W].
REQ-009 req_ready  output  N_REQ  bit i: requester i word accepted this cycle.
REQ-010 fifo_full  input  1  full flag of the downstream sync FIFO write port.
REQ-011 fifo_write_en  output  1  write strobe to FIFO.
REQ-012 fifo_data_in  output  W_DATA_W  write data to FIFO.
REQ-013 grant_id  output  ID_W  index of the currently granted requester.
REQ-014 busy  output  1  high while in GRANT state.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE, GRANT.
REQ-016 In IDLE with any req_valid bit set, the block SHALL select the first set bit searching from (last_id+1) mod N_REQ upward with wrap, load grant_id, clear burst_cnt, and enter GRANT on the next edge.
REQ-017 In IDLE, req_ready and fifo_write_en SHALL be 0 (one-cycle arbitration bubble).
REQ-018 In GRANT, xfer = req_valid[grant_id] & ~fifo_full; fifo_write_en = xfer; req_ready = xfer one-hot at bit grant_id, else 0 (combinational).
REQ-019 fifo_data_in SHALL equal req_data slice grant_id at all times (combinational mux).
REQ-020 Each xfer SHALL increment burst_cnt by 1.
REQ-021 GRANT SHALL exit to IDLE, setting last_id = grant_id, when xfer occurs with burst_cnt == MAX_BURST-1.
REQ-022 GRANT SHALL exit to IDLE, setting last_id = grant_id, when req_valid[grant_id] == 0 in that cycle.
REQ-023 fifo_full with req_valid[grant_id] high SHALL stall in GRANT: no xfer, no burst_cnt change, no release, unbounded.
REQ-024 Non-granted requesters SHALL never see req_ready high, regardless of fifo_full.
REQ-025 Round-robin SHALL guarantee each continuously valid requester a grant within N_REQ arbitration rounds.
REQ-026 Write-enable to the FIFO SHALL never be asserted while fifo_full is 1.
REQ-027 A requester dropping req_valid mid-burst SHALL lose the grant; remaining words re-arbitrate.

Reset
REQ-028 On rst: state IDLE, grant_id 0, last_id N_REQ-1 (requester 0 has first priority), burst_cnt 0, busy 0, req_ready 0, fifo_write_en 0.
REQ-029 Reset asserted mid-burst SHALL abort immediately; no write strobe during reset; after release the arbiter restarts from requester 0 priority.

Verification (N_REQ=4, MAX_BURST=4, W_DATA_W=8)
REQ-030 Reset release, all four req_valid held high -> grant order 0,1,2,3,0; each grant 4 writes; one IDLE cycle between grants; 20 writes per 20 cycles of GRANT+5 bubbles.
REQ-031 Only requester 2 valid, data 0x10..0x15 -> grant_id 2; writes 0x10..0x13, bubble, grant 2 again, writes 0x14,0x15, release on valid drop.
REQ-032 Requester 1 granted, fifo_full forced high for 5 cycles after 2nd word -> fifo_write_en 0 and req_ready 0 for those 5 cycles, grant held, words 3-4 written after full drops, then release.
REQ-033 Requester 3 valid for 2 words then deasserts -> 2 writes, release to IDLE, last_id 3, next valid requester 0 granted first.
REQ-034 rst pulsed while requester 2 mid-burst (burst_cnt 2) -> all outputs 0 same cycle; after release with requesters 2 and 0 valid, requester 0 granted first.
REQ-035 Scoreboard: sequence of fifo_data_in at fifo_write_en equals per-requester accepted words in order; no write while fifo_full; no req_ready to non-granted requester.
